// File: rtl/load_store_unit.sv
// Memory-access stage of the multicycle RV32I core.
// Accepts one load/store per instruction and drives a word-addressed data
// memory over a req/ready handshake. It generates byte enables and
// lane-replicated store data, and aligns and extends load data into a
// registered result that feeds the MDR.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for lsu_start; request fields latched on start
// ACCESS | mem_req high, waiting for mem_ready or wait-counter expiry
// RESP   | one-cycle lsu_done (with lsu_err if illegal or timed out)
module load_store_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic        lsu_clk,
    input  logic        lsu_rst_n,
    input  logic        lsu_start,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0]   r_rdata;

    logic          w_illegal;
    logic          w_timeout;
    logic [1:0]    w_off;
    logic [3:0]    w_store_be;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load_data;

    // Legality is judged on the live request so an illegal access never reaches ACCESS.
    always_comb begin
        w_illegal = 1'b0;
        case (lsu_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            3'b100, 3'b101:         w_illegal = lsu_we | (lsu_funct3[0] & lsu_addr[0]);
            3'b001:                 w_illegal = lsu_addr[0];
            3'b010:                 w_illegal = |lsu_addr[1:0];
            default:                w_illegal = 1'b0;
        endcase
    end

    // The last waiting cycle is the one in which the counter sits at WAIT_MAX-1.
    assign w_timeout = (r_wait_cnt == CW'(WAIT_MAX - 1));
    assign w_off     = r_addr[1:0];

    // State register.
    always_ff @(posedge lsu_clk or negedge lsu_rst_n) begin
        if (!lsu_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_start) w_next = w_illegal ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ready || w_timeout) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, error flag, wait counter and load result.
    always_ff @(posedge lsu_clk or negedge lsu_rst_n) begin
        if (!lsu_rst_n) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_rdata    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_start) begin
                        r_we     <= lsu_we;
                        r_funct3 <= lsu_funct3;
                        r_addr   <= lsu_addr;
                        r_wdata  <= lsu_wdata;
                        r_err    <= w_illegal;
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        if (!r_we) r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_err      <= 1'b0;
                    r_wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Store byte enables and lane replication.
    always_comb begin
        w_store_be = 4'b1111;
        mem_wdata  = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_store_be = 4'b0001 << w_off;
                mem_wdata  = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_store_be = 4'b0011 << w_off;
                mem_wdata  = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load field selection and extension.
    always_comb begin
        w_shifted   = mem_rdata >> {w_off, 3'b000};
        w_load_data = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    assign lsu_busy  = (r_state != S_IDLE);
    assign lsu_done  = (r_state == S_RESP);
    assign lsu_err   = (r_state == S_RESP) & r_err;
    assign lsu_rdata = r_rdata;
    assign mem_req   = (r_state == S_ACCESS);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_be    = mem_req ? (r_we ? w_store_be : 4'b1111) : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, loads with extension, stores,
// illegal accesses, timeout, back-to-back issue and asynchronous reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the last run_op
    int          obs_req_cnt;
    int          obs_done_cyc;
    logic        obs_err;
    logic        obs_we;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_done_after;

    load_store_unit #(.WAIT_MAX(15)) dut (
        .lsu_clk(clk), .lsu_rst_n(rst_n), .lsu_start(start), .lsu_we(we),
        .lsu_funct3(funct3), .lsu_addr(addr), .lsu_wdata(wdata),
        .lsu_busy(busy), .lsu_done(done), .lsu_err(err), .lsu_rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Issue one request and act as memory; ready_after = n raises ready in the
    // n-th request cycle, 0 never raises it. Cycle 1 is the first negedge after
    // the start edge.
    task automatic run_op(input logic i_we, input logic [2:0] i_f3, input logic [31:0] i_addr,
                          input logic [31:0] i_wdata, input logic [31:0] i_mdata, input int ready_after);
        @(negedge clk);
        start = 1'b1; we = i_we; funct3 = i_f3; addr = i_addr; wdata = i_wdata;
        mem_ready = 1'b0;
        obs_req_cnt = 0; obs_done_cyc = 0; obs_err = 1'b0; obs_rdata = 32'hx;
        obs_addr = 32'hx; obs_wdata = 32'hx; obs_be = 4'hx; obs_we = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                obs_done_cyc = c; obs_err = err; obs_rdata = rdata;
                break;
            end
            mem_ready = 1'b0;
            if (mem_req) begin
                obs_req_cnt++;
                obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
                if (ready_after != 0 && obs_req_cnt == ready_after) begin
                    mem_ready = 1'b1; mem_rdata = i_mdata;
                end
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        obs_done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, err, mem_req, mem_we, mem_be} !== 9'b0) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 000000000", {busy, done, err, mem_req, mem_we, mem_be});
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 00000000", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 00000000", mem_wdata); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_load();
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        n_cmp++;
        if (obs_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", obs_addr); end
        n_cmp++;
        if (obs_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", obs_be); end
        n_cmp++;
        if (obs_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %b want 0", obs_we); end
        n_cmp++;
        if (obs_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata got %h want deadbeef", obs_rdata); end
        n_cmp++;
        if (obs_done_cyc !== 2) begin n_bad++; $display("FAIL lw_latency got %0d want 2", obs_done_cyc); end
        n_cmp++;
        if (obs_err !== 1'b0) begin n_bad++; $display("FAIL lw_err got %b want 0", obs_err); end
        n_cmp++;
        if (obs_done_after !== 1'b0) begin n_bad++; $display("FAIL lw_done_pulse got %b want 0", obs_done_after); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h3, 32'h3, 32'h2, 32'h0};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        int          rdy [4] = '{1, 2, 1, 4};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, f3[i], ad[i], 32'h0, 32'h80FF7F01, rdy[i]);
            n_cmp++;
            if (obs_rdata !== exp[i] || obs_err !== 1'b0) begin
                n_bad++; $display("FAIL load_ext[%0d] got %h err %b want %h err 0", i, obs_rdata, obs_err, exp[i]);
            end
            n_cmp++;
            if (obs_done_cyc !== rdy[i] + 1) begin
                n_bad++; $display("FAIL load_ext_lat[%0d] got %0d want %0d", i, obs_done_cyc, rdy[i] + 1);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad [3] = '{32'h203, 32'h202, 32'h204};
        logic [31:0] ea [3] = '{32'h200, 32'h200, 32'h204};
        logic [3:0]  eb [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] ew [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, f3[i], ad[i], 32'h12345678, 32'hA5A5A5A5, 1);
            n_cmp++;
            if (obs_addr !== ea[i] || obs_be !== eb[i] || obs_wdata !== ew[i] || obs_we !== 1'b1) begin
                n_bad++;
                $display("FAIL store[%0d] got addr %h be %b wdata %h we %b want addr %h be %b wdata %h we 1",
                         i, obs_addr, obs_be, obs_wdata, obs_we, ea[i], eb[i], ew[i]);
            end
            n_cmp++;
            if (obs_rdata !== 32'h00007F01 || obs_err !== 1'b0 || obs_done_cyc !== 2) begin
                n_bad++;
                $display("FAIL store_hold[%0d] got rdata %h err %b lat %0d want 00007f01 0 2", i, obs_rdata, obs_err, obs_done_cyc);
            end
        end
    endtask

    task automatic test_misaligned();
        logic        wv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        logic [31:0] ad [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
        for (int i = 0; i < 4; i++) begin
            run_op(wv[i], f3[i], ad[i], 32'hFFFFFFFF, 32'h13579BDF, 1);
            n_cmp++;
            if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_req_cnt !== 0) begin
                n_bad++;
                $display("FAIL illegal[%0d] got lat %0d err %b req %0d want 1 1 0", i, obs_done_cyc, obs_err, obs_req_cnt);
            end
            n_cmp++;
            if (obs_rdata !== 32'h00007F01) begin
                n_bad++; $display("FAIL illegal_rdata[%0d] got %h want 00007f01", i, obs_rdata);
            end
        end
    endtask

    task automatic test_timeout();
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0);
        n_cmp++;
        if (obs_req_cnt !== 15) begin n_bad++; $display("FAIL timeout_req got %0d want 15", obs_req_cnt); end
        n_cmp++;
        if (obs_done_cyc !== 16 || obs_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_done got lat %0d err %b want 16 1", obs_done_cyc, obs_err);
        end
        n_cmp++;
        if (obs_rdata !== 32'h00007F01) begin n_bad++; $display("FAIL timeout_rdata got %h want 00007f01", obs_rdata); end
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 1);
        n_cmp++;
        if (obs_rdata !== 32'hCAFEF00D || obs_err !== 1'b0 || obs_done_cyc !== 2) begin
            n_bad++;
            $display("FAIL after_timeout got rdata %h err %b lat %0d want cafef00d 0 2", obs_rdata, obs_err, obs_done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] done_mask = 8'h0;
        @(negedge clk);
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h400;
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) start = 1'b0;
            done_mask[c] = done;
        end
        mem_ready = 1'b0;
        n_cmp++;
        if (done_mask !== 8'b0010_0100) begin n_bad++; $display("FAIL b2b_done got %b want 00100100", done_mask); end
        n_cmp++;
        if (rdata !== 32'h11112222) begin n_bad++; $display("FAIL b2b_rdata got %h want 11112222", rdata); end
    endtask

    task automatic test_async_reset();
        logic saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre got req %b busy %b want 1 1", mem_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL arst_drop got req %b busy %b want 0 0", mem_req, busy);
        end
        n_cmp++;
        if ({done, err, mem_we, mem_be} !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL arst_vals got done %b err %b we %b be %b addr %h wdata %h rdata %h want all zero",
                     done, err, mem_we, mem_be, mem_addr, mem_wdata, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        mem_ready = 1'b0;
        n_cmp++;
        if (saw_done !== 1'b0) begin n_bad++; $display("FAIL arst_no_done got %b want 0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the multicycle RV32I core, sitting between the control/ALU stage and the memory data register. It takes one load or store request per instruction, drives a word-addressed data memory through a req/ready handshake, and generates byte enables and replicated store data. It extracts and sign- or zero-extends load data, which it presents on `lsu_rdata` as the input to the memory data register, and flags misaligned or invalid accesses and bus timeouts.

## Interface
- `WAIT_MAX`, default 15: maximum number of cycles spent in ACCESS without `mem_ready` before a timeout error.

- `lsu_clk` input 1: single clock; all state changes on the rising edge.
- `lsu_rst_n` input 1: asynchronous, active-low reset.
- `lsu_start` input 1: request strobe from the control unit; sampled only in IDLE.
- `lsu_we` input 1: 1 = store, 0 = load.
- `lsu_funct3` input 3: RV32I width/sign code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `lsu_addr` input 32: effective byte address.
- `lsu_wdata` input 32: store source (rs2).
- `lsu_busy` output 1: high whenever the state is not IDLE.
- `lsu_done` output 1: one-cycle completion pulse.
- `lsu_err` output 1: one-cycle error pulse, coincident with `lsu_done`.
- `lsu_rdata` output 32: aligned and extended load result, registered; feeds the MDR.
- `mem_req` output 1: access request to data memory.
- `mem_we` output 1: write strobe, valid while `mem_req` is high.
- `mem_addr` output 32: word address, equal to {addr[31:2], 2'b00}.
- `mem_be` output 4: byte enables; bit i selects byte lane i.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rdata` input 32: read data, valid in the cycle `mem_ready` is high.
- `mem_ready` input 1: completes the access in the cycle in which it is sampled high with `mem_req` high.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE, `lsu_start` = 1:**
  - Latch we, funct3, addr and wdata.
  - Legal access: go to ACCESS.
  - Illegal access: go directly to RESP with error set; `mem_req` is never raised.
- **Illegal access** is any of:
  - funct3 ∈ {011, 110, 111};
  - a store with funct3 100 or 101;
  - H/HU with addr[0] = 1;
  - W with addr[1:0] ≠ 00.
- **ACCESS:**
  - `mem_req` = 1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from the latched values and held stable until ready.
  - `mem_ready` = 1: go to RESP. For loads, `lsu_rdata` is updated at that edge.
  - Wait counter increments each cycle without ready. When it reaches `WAIT_MAX`, go to RESP with error set and leave `lsu_rdata` unchanged.
- **RESP:** `lsu_done` = 1 and `lsu_err` = error flag for exactly one cycle, then go to IDLE. The error flag and wait counter clear on entry to IDLE.
- **Store lanes** (off = addr[1:0]):
  - SB: be = 0001 << off; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << off; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111; wdata passed through unchanged.
- **Loads:** `mem_be` = 1111. The selected field is `mem_rdata` >> (8·off).
  - B/H: sign-extend from bit 7 / bit 15.
  - BU/HU: zero-extend.
  - W: passed through unchanged.
- **Holding behaviour:**
  - `lsu_rdata` holds its value across stores, errors and idle cycles.
  - `lsu_start` outside IDLE is ignored; no queueing.

## Timing
- **Reset values:** state IDLE; `lsu_busy`, `lsu_done`, `lsu_err`, `mem_req`, `mem_we` = 0; `mem_be` = 0000; `mem_addr`, `mem_wdata`, `lsu_rdata` = 0.
- **Asserting `lsu_rst_n` = 0 mid-access** drops `mem_req` immediately (asynchronously) and abandons the transaction; no done pulse is produced.
- **Latency, legal access:**
  - start sampled at edge 0;
  - `mem_req` high from edge 0;
  - ready sampled at edge k (k ≥ 1);
  - `lsu_done` high in the cycle after edge k.
  - Minimum latency is 2 cycles from start to done.
- **Latency, illegal access:** `lsu_done` and `lsu_err` are high in the cycle after edge 0.
- **Timeout:** `mem_req` is high for `WAIT_MAX` cycles, then RESP follows with `lsu_err` = 1.
- **Ready outside ACCESS:** ignored.
- **Back-to-back:** a new start is accepted at the first IDLE edge after RESP, i.e. a 3-cycle minimum initiation interval.

## Test plan
- **Word load:** LW at addr 0x100, memory returns 0xDEADBEEF with ready one cycle after req → `mem_addr` = 0x100, `mem_be` = 1111, `lsu_rdata` = 0xDEADBEEF, single `lsu_done` pulse, `lsu_err` = 0.
- **Byte/halfword extension:** `mem_rdata` = 0x80FF7F01.
  - LB at off 3 → 0xFFFFFF80.
  - LBU at off 3 → 0x00000080.
  - LH at off 2 → 0xFFFF80FF.
  - LHU at off 0 → 0x00007F01.
- **Stores:** wdata 0x12345678.
  - SB at 0x203 → be 1000, `mem_wdata` 0x78787878, `mem_addr` 0x200.
  - SH at 0x202 → be 1100, `mem_wdata` 0x56785678.
- **Misaligned access:** LW at 0x102 → `lsu_done` = `lsu_err` = 1 one cycle after start, `mem_req` never high, `lsu_rdata` unchanged.
- **Timeout:** `WAIT_MAX` = 15, `mem_ready` held low → `mem_req` high exactly 15 cycles, then done + err; a subsequent LW with immediate ready completes normally.
- **Async reset:** `lsu_rst_n` pulsed low during ACCESS → `mem_req` and `lsu_busy` drop without waiting for a clock edge, all outputs return to reset values, and no `lsu_done` pulse is produced.
